// File: rtl/ddr_port_arbiter_if.sv
// Bus bundle for ddr_port_arbiter: read master, write master and DDR Avalon-MM port.
// The arbiter uses the slave view; the environment driving masters and memory uses master.
interface ddr_port_arbiter_if;
  logic [15:0] rd_addr;
  logic        rd_read;
  logic        rd_waitrequest;
  logic [15:0] rd_readdata;
  logic        rd_readdatavalid;
  logic [15:0] wr_addr;
  logic        wr_write;
  logic [15:0] wr_writedata;
  logic        wr_waitrequest;
  logic [15:0] ddr_addr;
  logic        ddr_read;
  logic        ddr_write;
  logic [15:0] ddr_writedata;
  logic [15:0] ddr_readdata;
  logic        ddr_readdatavalid;
  logic        ddr_waitrequest;

  modport slave (
    input  rd_addr, rd_read, wr_addr, wr_write, wr_writedata,
           ddr_readdata, ddr_readdatavalid, ddr_waitrequest,
    output rd_waitrequest, rd_readdata, rd_readdatavalid, wr_waitrequest,
           ddr_addr, ddr_read, ddr_write, ddr_writedata
  );

  modport master (
    output rd_addr, rd_read, wr_addr, wr_write, wr_writedata,
           ddr_readdata, ddr_readdatavalid, ddr_waitrequest,
    input  rd_waitrequest, rd_readdata, rd_readdatavalid, wr_waitrequest,
           ddr_addr, ddr_read, ddr_write, ddr_writedata
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR Avalon-MM port between a streaming reader and a writer, round-robin with a hold limit.
// Define DDR_ARB_WR_PRIO_EN to give the writer tie priority and exemption from the hold limit.
module ddr_port_arbiter #(
  parameter int MAX_HOLD    = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  ddr_port_arbiter_if.slave   bus,
  output logic [1:0]          owner,
  output logic [3:0]          pending
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

`ifdef DDR_ARB_WR_PRIO_EN
  localparam bit WR_PRIO = 1'b1;
`else
  localparam bit WR_PRIO = 1'b0;
`endif

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

  state_t      state;
  state_t      last;
  state_t      other;
  state_t      tie_winner;
  logic [7:0]  hold_cnt;
  logic        pend_full;
  logic        rd_acc;
  logic        wr_acc;
  logic        req;
  logic        oth;
  logic        acc;
  logic        hold_hit;
  logic        may_preempt;

  assign owner                = state;
  assign pend_full            = (pending == PEND_MAX);
  assign rd_acc               = (state == RD) && bus.ddr_read  && !bus.ddr_waitrequest;
  assign wr_acc               = (state == WR) && bus.ddr_write && !bus.ddr_waitrequest;
  assign hold_hit             = (hold_cnt == HOLD_MAX - 8'd1);
  assign may_preempt          = !(WR_PRIO && state == WR);
  assign bus.rd_readdata      = bus.ddr_readdata;
  assign bus.rd_readdatavalid = bus.ddr_readdatavalid;

  always_comb begin
    bus.ddr_addr       = '0;
    bus.ddr_writedata  = '0;
    bus.ddr_read       = 1'b0;
    bus.ddr_write      = 1'b0;
    bus.rd_waitrequest = 1'b1;
    bus.wr_waitrequest = 1'b1;
    req                = 1'b0;
    oth                = 1'b0;
    acc                = 1'b0;
    other              = IDLE;
    tie_winner         = (WR_PRIO || last == RD) ? WR : RD;
    case (state)
      RD: begin
        bus.ddr_addr       = bus.rd_addr;
        bus.ddr_read       = bus.rd_read && !pend_full;
        bus.rd_waitrequest = bus.ddr_waitrequest || pend_full;
        req                = bus.rd_read;
        oth                = bus.wr_write;
        acc                = rd_acc;
        other              = WR;
      end
      WR: begin
        bus.ddr_addr       = bus.wr_addr;
        bus.ddr_writedata  = bus.wr_writedata;
        bus.ddr_write      = bus.wr_write;
        bus.wr_waitrequest = bus.ddr_waitrequest;
        req                = bus.wr_write;
        oth                = bus.rd_read;
        acc                = wr_acc;
        other              = RD;
      end
      default: ;
    endcase
  end

  // Readdatavalid may arrive after a reset wiped the count, so the decrement is floored at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= WR;
      hold_cnt <= '0;
      pending  <= '0;
    end else begin
      if (rd_acc && !bus.ddr_readdatavalid)
        pending <= pending + 4'd1;
      else if (!rd_acc && bus.ddr_readdatavalid && pending != 4'd0)
        pending <= pending - 4'd1;

      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (bus.rd_read && bus.wr_write) state <= tie_winner;
          else if (bus.rd_read)            state <= RD;
          else if (bus.wr_write)           state <= WR;
        end
        default: begin
          if (!req) begin
            state    <= oth ? other : IDLE;
            last     <= state;
            hold_cnt <= '0;
          end else if (acc && hold_hit && oth && may_preempt) begin
            state    <= other;
            last     <= state;
            hold_cnt <= '0;
          end else if (acc && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Shares one DDR3 Avalon-MM port between the streaming read_master (sample source) and write_master (synthesized-speech sink) so the LPC encode/decode chain runs against a single physical memory. It grants the port to one master at a time, passes its command through, and limits outstanding reads. It returns read data to read_master in order.

## Interface
- MAX_HOLD, 16: consecutive accepted transfers an owner may make while the other side is requesting (1..255).
- MAX_PENDING, 8: maximum outstanding reads (accepted, data not yet returned), 1..15.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  16  read_master address
- rd_read  in  1  read_master read request
- rd_waitrequest  out  1  stall to read_master
- rd_readdata  out  16  read data to read_master
- rd_readdatavalid  out  1  read data valid to read_master
- wr_addr  in  16  write_master address
- wr_write  in  1  write_master write request
- wr_writedata  in  16  write_master data
- wr_waitrequest  out  1  stall to write_master
- ddr_addr  out  16  memory address
- ddr_read  out  1  memory read
- ddr_write  out  1  memory write
- ddr_writedata  out  16  memory write data
- ddr_readdata  in  16  memory read data
- ddr_readdatavalid  in  1  memory read data valid
- ddr_waitrequest  in  1  memory stall
- owner  out  2  0 = IDLE, 1 = RD, 2 = WR (state register)
- pending  out  4  outstanding read count

## Operation
- States: IDLE, RD, WR. Registers: state, last (last owner served), hold_cnt[7:0], pending.
- Accept: rd_acc = state==RD & ddr_read & ~ddr_waitrequest. wr_acc = state==WR & ddr_write & ~ddr_waitrequest.
- IDLE:
  - ddr_read, ddr_write, ddr_addr and ddr_writedata are 0. Both waitrequests are 1.
  - If only rd_read is high, go to RD. If only wr_write is high, go to WR.
  - If both are high, go to the side opposite last.
  - hold_cnt is cleared on every entry to RD or WR.
- RD:
  - ddr_addr = rd_addr. ddr_read = rd_read & ~pend_full. rd_waitrequest = ddr_waitrequest | pend_full. wr_waitrequest = 1.
  - pend_full = (pending == MAX_PENDING).
- WR:
  - ddr_addr = wr_addr. ddr_writedata = wr_writedata. ddr_write = wr_write. wr_waitrequest = ddr_waitrequest. rd_waitrequest = 1.
- Leaving an owner state, evaluated each cycle with the owner's request (req) and other side's request (oth):
  - If req is 0: go to WR or RD if oth is high, else IDLE. Set last = current owner.
  - Else if an accept occurs this cycle, hold_cnt+1 == MAX_HOLD, and oth is high: switch directly to the other owner state. Set last = current owner.
  - Otherwise stay. hold_cnt increments on each accept and saturates at MAX_HOLD.
- Read return:
  - rd_readdata = ddr_readdata and rd_readdatavalid = ddr_readdatavalid, combinational, in any state including WR.
  - pending += rd_acc, pending -= ddr_readdatavalid. Both in the same cycle leaves it unchanged. pending never goes below 0.
- Writes may be granted while reads are pending; memory returns read data in order.

## Timing
- Reset values:
  - Registers: state IDLE, last WR (first tie goes to RD), hold_cnt 0, pending 0.
  - Outputs: owner 0, pending 0, ddr_read 0, ddr_write 0, ddr_addr 0, ddr_writedata 0, rd_waitrequest 1, wr_waitrequest 1.
  - rd_readdata and rd_readdatavalid follow memory even during reset.
- Grant latency: a request seen in IDLE at edge N is forwarded to memory in cycle N+1. An owner-to-owner switch takes 0 idle cycles.
- Reset mid-operation clears pending. Later ddr_readdatavalid pulses still pass through but do not underflow pending.
- Command outputs are combinational from state and inputs. No added pipeline latency in the command or return path.

## Configuration
- DDR_ARB_WR_PRIO_EN defined:
  - On an IDLE tie, WR always wins.
  - WR ignores MAX_HOLD and keeps the port until wr_write drops.
  - RD is still preempted at MAX_HOLD.
- DDR_ARB_WR_PRIO_EN undefined: round-robin as described above.
- Purpose: DDR_ARB_WR_PRIO_EN protects the synthesis sink from overflow.

## Test plan
- Reads only, rd_read held 20 cycles, memory read latency 3, no waitrequest:
  - owner goes 1 one cycle after the request.
  - 20 accepts, in order.
  - pending peaks at 3 and returns to 0.
- Both masters request continuously from reset, MAX_HOLD=4, macro undefined:
  - Grant sequence is RD×4, WR×4, RD×4, …
  - No idle cycle between owners.
- Read memory latency 20, MAX_PENDING=8:
  - ddr_read deasserts after 8 accepts.
  - rd_waitrequest stays 1 until the first readdatavalid.
- ddr_waitrequest held high 5 cycles during WR:
  - wr_waitrequest is high for those 5 cycles.
  - hold_cnt does not advance.
  - wr_writedata 16'h1234 reaches memory unchanged.
- DDR_ARB_WR_PRIO_EN defined, both request:
  - WR granted first.
  - WR holds 40 transfers.
  - RD is granted only after wr_write drops.
- rst asserted with pending=5, then 5 stray readdatavalid pulses:
  - pending stays 0.
  - owner is 0 the cycle after the reset edge.
